// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder for the processor data port: one access at a time,
// WAIT_CYCLES wait states, then a one-cycle dReady (legal) or dErr (rejected) pulse.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH       = 128,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic [3:0]  dByteEn,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dErr,
  output logic        busy
);
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] ADDR_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic        r_legal;
  logic        r_wr;
  logic [AW-1:0] r_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH];

  logic        w_req;
  logic [32:0] w_addr_ext;
  logic        w_in_range;
  logic        w_legal_in;
  logic [AW-1:0] w_idx_in;
  logic        w_enter_resp;
  logic        w_acc_legal;
  logic        w_acc_wr;
  logic [AW-1:0] w_acc_idx;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_be;

  // Classification is done on the live request so it can be latched at acceptance.
  assign w_req      = MemRead | MemWrite;
  assign w_addr_ext = {1'b0, dAddress};
  assign w_in_range = (w_addr_ext >= ADDR_LO) && (w_addr_ext < ADDR_HI);
  assign w_legal_in = !(MemRead && MemWrite) && (dAddress[1:0] == 2'b00) && w_in_range;
  assign w_idx_in   = AW'((dAddress - BASE_ADDR) >> 2);

  // With zero wait states the access happens on the accepting edge, so use the live request.
  assign w_acc_legal = (r_state == S_IDLE) ? w_legal_in : r_legal;
  assign w_acc_wr    = (r_state == S_IDLE) ? MemWrite   : r_wr;
  assign w_acc_idx   = (r_state == S_IDLE) ? w_idx_in   : r_idx;
  assign w_acc_wdata = (r_state == S_IDLE) ? dWriteData : r_wdata;
  assign w_acc_be    = (r_state == S_IDLE) ? dByteEn    : r_be;
  assign w_enter_resp = rst && (r_state != S_RESP) && (w_next_state == S_RESP);

  // Next-state and wait-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = WAIT_INIT;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State, latched request, and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_legal   <= 1'b0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      r_be      <= 4'd0;
      dReadData <= 32'd0;
      dReady    <= 1'b0;
      dErr      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if ((r_state == S_IDLE) && w_req) begin
        r_legal <= w_legal_in;
        r_wr    <= MemWrite;
        r_idx   <= w_idx_in;
        r_wdata <= dWriteData;
        r_be    <= dByteEn;
      end
      dReady <= w_enter_resp && w_acc_legal;
      dErr   <= w_enter_resp && !w_acc_legal;
      busy   <= (w_next_state != S_IDLE);
      if (w_enter_resp && w_acc_legal && !w_acc_wr) begin
        dReadData <= r_mem[w_acc_idx];
      end
    end
  end

  // Byte-lane store into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_acc_legal && w_acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) begin
          r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share
// stimulus and are checked every cycle against a timestamp-based transaction model.
module tb_data_mem_responder;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dAddress = 32'd0;
  logic [31:0] dWriteData = 32'd0;
  logic [3:0]  dByteEn = 4'd0;
  logic [31:0] d2_rdata, d0_rdata;
  logic        d2_ready, d2_err, d2_busy, d0_ready, d0_err, d0_busy;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .dAddress(dAddress),
    .dWriteData(dWriteData), .dByteEn(dByteEn), .dReadData(d2_rdata), .dReady(d2_ready),
    .dErr(d2_err), .busy(d2_busy));

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .dAddress(dAddress),
    .dWriteData(dWriteData), .dByteEn(dByteEn), .dReadData(d0_rdata), .dReady(d0_ready),
    .dErr(d0_err), .busy(d0_busy));

  // Transaction model: index 0 models the 2-wait instance, index 1 the 0-wait instance.
  logic [31:0] m_mem [2][DEPTH];
  bit          m_pend [2];
  longint      m_acc [2];
  longint      m_free [2];
  bit          m_legal [2];
  bit          m_wr [2];
  int          m_idx [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_be [2];
  logic [31:0] x_rdata [2];
  bit          x_ready [2];
  bit          x_err [2];
  bit          x_busy [2];
  longint      e = 0;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    return !(rd && wr) && (a[1:0] == 2'b00) && (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_free[k] = 0;
      x_rdata[k] = 32'd0; x_ready[k] = 1'b0; x_err[k] = 1'b0; x_busy[k] = 1'b0;
    end
  endtask

  // Accepted at edge A: busy through edge A+W, pulse after edge A+W, next accept at A+W+2.
  task automatic model_step();
    e++;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        x_ready[k] = 1'b0;
        x_err[k]   = 1'b0;
        if (m_pend[k] && e == m_acc[k] + wc(k) + 1) m_pend[k] = 1'b0;
        if (!m_pend[k] && (MemRead || MemWrite) && e >= m_free[k]) begin
          m_pend[k]  = 1'b1;
          m_acc[k]   = e;
          m_free[k]  = e + wc(k) + 2;
          m_legal[k] = is_legal(MemRead, MemWrite, dAddress);
          m_wr[k]    = MemWrite;
          m_idx[k]   = int'((longint'(dAddress) - longint'(BASE)) / 4);
          m_wd[k]    = dWriteData;
          m_be[k]    = dByteEn;
        end
        if (m_pend[k] && e == m_acc[k] + wc(k)) begin
          if (m_legal[k]) begin
            x_ready[k] = 1'b1;
            if (m_wr[k]) begin
              for (int b = 0; b < 4; b++)
                if (m_be[k][b]) m_mem[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
            end else begin
              x_rdata[k] = m_mem[k][m_idx[k]];
            end
          end else begin
            x_err[k] = 1'b1;
          end
        end
        x_busy[k] = m_pend[k];
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("w2.dReady",    32'(d2_ready), 32'(x_ready[0]));
      check("w2.dErr",      32'(d2_err),   32'(x_err[0]));
      check("w2.busy",      32'(d2_busy),  32'(x_busy[0]));
      check("w2.dReadData", d2_rdata,      x_rdata[0]);
      check("w0.dReady",    32'(d0_ready), 32'(x_ready[1]));
      check("w0.dErr",      32'(d0_err),   32'(x_err[1]));
      check("w0.busy",      32'(d0_busy),  32'(x_busy[1]));
      check("w0.dReadData", d0_rdata,      x_rdata[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Holds a request until the 2-wait instance completes it, then drops it for one idle cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output bit rdy, output bit err, output int n);
    MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = d; dByteEn = be;
    n = 0; rdy = 1'b0; err = 1'b0;
    while (!(rdy || err) && n < 20) begin
      tick();
      n++;
      rdy = d2_ready;
      err = d2_err;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    if (!(rdy || err)) begin
      n_cmp++; n_fail++;
      $display("FAIL do_req_timeout: addr %h got no completion, expected one within %0d cycles", a, n);
    end
    tick();
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check({tag, ".rdata"}, d2_rdata,      32'h0000_0000);
    check({tag, ".ready"}, 32'(d2_ready), 32'h0);
    check({tag, ".err"},   32'(d2_err),   32'h0);
    check({tag, ".busy"},  32'(d2_busy),  32'h0);
  endtask

  initial begin
    bit rdy, err;
    int n;
    bit er_rd [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit er_wr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] er_a [4] = '{32'h1001_0002, 32'h1001_0200, 32'h1000_FFFC, 32'h1001_0008};

    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("por.rdata", d2_rdata, 32'h0);
    check("por.busy",  32'(d2_busy), 32'h0);
    chk_en = 1'b1;
    tick();
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      do_req(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rdy, err, n);

    // Store / load / store-keeps-rdata / byte lane.
    do_req(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, rdy, err, n);
    check("st.ready", 32'(rdy), 32'h1);
    do_req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'h0, rdy, err, n);
    check("ld.rdata", d2_rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 32'h1001_0010, 32'h1234_5678, 4'hF, rdy, err, n);
    check("st.keeps_rdata", d2_rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 32'h1001_0008, 32'h1122_3344, 4'b0010, rdy, err, n);
    do_req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'h0, rdy, err, n);
    check("lane.rdata", d2_rdata, 32'hDEAD_33EF);

    // Rejected requests: dErr only, memory and dReadData untouched.
    for (int i = 0; i < 4; i++) begin
      do_req(er_rd[i], er_wr[i], er_a[i], 32'h0, 4'hF, rdy, err, n);
      check("err.pulse", 32'(err), 32'h1);
      check("err.no_ready", 32'(rdy), 32'h0);
      check("err.rdata", d2_rdata, 32'hDEAD_33EF);
    end
    do_req(1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'h0, rdy, err, n);
    do_req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'h0, rdy, err, n);
    check("err.mem_kept", d2_rdata, 32'hDEAD_33EF);

    // Reset during the WAIT of a store aborts it.
    MemWrite = 1'b1; dAddress = 32'h1001_0008; dWriteData = 32'h0; dByteEn = 4'hF;
    tick();
    check("abort.busy_before", 32'(d2_busy), 32'h1);
    MemWrite = 1'b0;
    async_reset_check("abort");
    tick();
    rst = 1'b1;
    do_req(1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'h0, rdy, err, n);
    check("latency", 32'(n), 32'd3);
    do_req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'h0, rdy, err, n);
    check("abort.mem_kept", d2_rdata, 32'hDEAD_33EF);

    // Zero-wait instance under a held request: completes every other cycle.
    tick();
    MemRead = 1'b1; dAddress = 32'h1001_0004;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("w0.toggle_busy",  32'(d0_busy),  32'((i % 2) == 0));
      check("w0.toggle_ready", 32'(d0_ready), 32'((i % 2) == 0));
    end
    MemRead = 1'b0;
    tick();

    // Randomized traffic including illegal addresses, zero byte-enables and async resets.
    for (int c = 0; c < 4000; c++) begin
      int op = $urandom_range(0, 9);
      int ak = $urandom_range(0, 9);
      MemRead  = (op <= 3) || (op == 8);
      MemWrite = (op >= 4 && op <= 8);
      case (ak)
        0: dAddress = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        1: dAddress = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        2: dAddress = BASE - 32'(4 * $urandom_range(1, 4));
        3: dAddress = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : $urandom;
        default: dAddress = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      dWriteData = $urandom;
      dByteEn    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) begin
        async_reset_check("rnd_reset");
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
